// File: rtl/cmd_seq_pkg.sv
// ============================================================================
// Module   : cmd_seq_pkg
// Purpose  : Shared types and constants for the command slot sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmd_seq_pkg;

   localparam int NUM_SLOTS = 8;
   localparam int IDX_W     = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/cmd_seq_timer.sv
// ============================================================================
// Module   : cmd_seq_timer
// Purpose  : Slot-period counter; counts 0..period-1 and flags the last cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_seq_timer #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_period,
   output logic             o_wrap
);

   localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   assign w_last = (r_cnt == (i_period - c_one));
   assign o_wrap = i_en && w_last;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_last ? '0 : (r_cnt + c_one);
      end
   end

endmodule

`default_nettype wire

// File: rtl/cmd_seq_ctrl.sv
// ============================================================================
// Module   : cmd_seq_ctrl
// Purpose  : Eight-slot pattern sequencer with shadowed command words.
//            Define CMD_SEQ_SHADOW_EN to defer new commands to frame end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_seq_ctrl
   import cmd_seq_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_valid,
   input  logic [7:0]       ctrl_set,
   input  logic [CNT_W-1:0] time_set,
   output logic             seq_out,
   output logic [IDX_W-1:0] seq_idx,
   output logic             seq_busy,
   output logic             cfg_ack,
   output logic             frame_done
);

   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_SLOTS - 1);
   localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);

   state_t           r_state;
   logic             r_pend;
   logic [7:0]       r_sh_ctrl;
   logic [CNT_W-1:0] r_sh_time;
   logic [7:0]       r_act_ctrl;
   logic [CNT_W-1:0] r_act_time;
   logic [IDX_W-1:0] r_idx;
   logic             r_seq_out;

   logic [7:0]       w_sh_ctrl;
   logic [CNT_W-1:0] w_sh_time;
   logic             w_pend;
   logic             w_wrap;
   logic             w_frame_end;
   logic             w_run_apply;
   logic             w_apply;
   logic             w_go_load;
   logic [IDX_W-1:0] w_idx_nxt;

   // A strobe in this very cycle counts as pending, so decisions see it now.
   assign w_sh_ctrl = cfg_valid ? ctrl_set : r_sh_ctrl;
   assign w_sh_time = cfg_valid ? time_set : r_sh_time;
   assign w_pend    = cfg_valid || r_pend;

   assign w_frame_end = w_wrap && (r_idx == c_last_idx);
   assign w_idx_nxt   = r_idx + c_idx_one;

`ifdef CMD_SEQ_SHADOW_EN
   assign w_run_apply = w_frame_end && w_pend;
`else
   assign w_run_apply = cfg_valid || (w_frame_end && w_pend);
`endif

   assign w_apply   = ((r_state == IDLE) && w_pend) ||
                      ((r_state == RUN)  && w_run_apply);
   assign w_go_load = w_apply && (w_sh_time != '0);

   cmd_seq_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_go_load),
      .i_en     (r_state == RUN),
      .i_period (r_act_time),
      .o_wrap   (w_wrap)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_pend     <= 1'b0;
         r_sh_ctrl  <= '0;
         r_sh_time  <= '0;
         r_act_ctrl <= '0;
         r_act_time <= '0;
         r_idx      <= '0;
         r_seq_out  <= 1'b0;
      end else begin
         if (cfg_valid) begin
            r_sh_ctrl <= ctrl_set;
            r_sh_time <= time_set;
         end
         if (w_apply) begin
            r_pend    <= 1'b0;
            r_idx     <= '0;
            r_seq_out <= 1'b0;
            if (w_go_load) begin
               r_state    <= LOAD;
               r_act_ctrl <= w_sh_ctrl;
               r_act_time <= w_sh_time;
            end else begin
               r_state <= IDLE;
            end
         end else begin
            if (cfg_valid) begin
               r_pend <= 1'b1;
            end
            case (r_state)
               LOAD: begin
                  r_state   <= RUN;
                  r_idx     <= '0;
                  r_seq_out <= r_act_ctrl[0];
               end
               RUN: begin
                  if (w_wrap) begin
                     r_idx     <= w_idx_nxt;
                     r_seq_out <= r_act_ctrl[w_idx_nxt];
                  end
               end
               default: begin
                  r_state   <= IDLE;
                  r_idx     <= '0;
                  r_seq_out <= 1'b0;
               end
            endcase
         end
      end
   end

   assign seq_out    = r_seq_out;
   assign seq_idx    = r_idx;
   assign seq_busy   = (r_state != IDLE);
   assign cfg_ack    = (r_state == LOAD);
   assign frame_done = w_frame_end;

endmodule

`default_nettype wire

// File: tb/tb_cmd_seq_ctrl.sv
// ============================================================================
// Module   : tb_cmd_seq_ctrl
// Purpose  : Self-checking bench for cmd_seq_ctrl (reference model + directed).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmd_seq_ctrl;

   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             cfg_valid;
   logic [7:0]       ctrl_set;
   logic [CNT_W-1:0] time_set;
   logic             seq_out;
   logic [2:0]       seq_idx;
   logic             seq_busy;
   logic             cfg_ack;
   logic             frame_done;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   cmd_seq_ctrl #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .cfg_valid  (cfg_valid),
      .ctrl_set   (ctrl_set),
      .time_set   (time_set),
      .seq_out    (seq_out),
      .seq_idx    (seq_idx),
      .seq_busy   (seq_busy),
      .cfg_ack    (cfg_ack),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: phase 0 idle, 1 acknowledging, 2 running; position counts cycles within a frame.
   int         m_phase = 0;
   logic [7:0] m_pat   = 8'h00;
   longint     m_per   = 0;
   longint     m_pos   = 0;
   bit         m_hp    = 1'b0;
   logic [7:0] m_pp    = 8'h00;
   longint     m_pper  = 0;

   always @(posedge clk) begin
      bit         np;
      bit         fe;
      bit         apply;
      logic [7:0] npat;
      longint     nper;
      if (reset) begin
         m_phase = 0; m_hp = 1'b0; m_pp = 8'h00; m_pper = 0;
         m_pat = 8'h00; m_per = 0; m_pos = 0;
      end else begin
         np    = m_hp || cfg_valid;
         npat  = cfg_valid ? ctrl_set : m_pp;
         nper  = cfg_valid ? longint'(time_set) : m_pper;
         fe    = (m_phase == 2) && (m_pos == 8 * m_per - 1);
         apply = 1'b0;
         if (m_phase == 0) apply = np;
         else if (m_phase == 2) begin
`ifdef CMD_SEQ_SHADOW_EN
            apply = fe && np;
`else
            apply = cfg_valid || (fe && np);
`endif
         end
         if (apply) begin
            m_hp = 1'b0;
            if (nper != 0) begin
               m_phase = 1; m_pat = npat; m_per = nper;
            end else begin
               m_phase = 0;
            end
         end else begin
            if (cfg_valid) begin
               m_hp = 1'b1; m_pp = npat; m_pper = nper;
            end
            if (m_phase == 1) begin
               m_phase = 2; m_pos = 0;
            end else if (m_phase == 2) begin
               m_pos = fe ? 0 : m_pos + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      longint slot;
      logic   e_out;
      logic   e_fd;
      logic [2:0] e_idx;
      if (chk_en) begin
         e_out = 1'b0; e_fd = 1'b0; e_idx = 3'd0;
         if (m_phase == 2) begin
            slot  = m_pos / m_per;
            e_idx = slot[2:0];
            e_out = m_pat[int'(slot)];
            e_fd  = (m_pos == 8 * m_per - 1);
         end
         cmp("m_busy", seq_busy, m_phase != 0);
         cmp("m_ack", cfg_ack, m_phase == 1);
         cmp("m_out", seq_out, e_out);
         cmp("m_idx", seq_idx, e_idx);
         cmp("m_fd", frame_done, e_fd);
      end
   end

   task automatic step(input logic v, input logic [7:0] c, input logic [CNT_W-1:0] t, input logic r);
      reset = r; cfg_valid = v; ctrl_set = c; time_set = t;
      @(negedge clk);
      #1;
   endtask

   initial begin
      int exp032 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
      int exp033 [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
      int tab [8]    = '{0, 1, 1, 2, 3, 4, 5, 2};
      logic v;
      logic r;

      reset = 1'b1; cfg_valid = 1'b0; ctrl_set = 8'h00; time_set = '0;
      @(negedge clk);
      #1;
      chk_en = 1'b1;
      cmp("rst_busy", seq_busy, 0);
      cmp("rst_out", seq_out, 0);
      cmp("rst_ack", cfg_ack, 0);
      cmp("rst_idx", seq_idx, 0);

      step(1'b1, 8'hA5, 3, 1'b0);
      cmp("a5_ack", cfg_ack, 1);
      cmp("a5_load_out", seq_out, 0);
      for (int k = 0; k < 24; k++) begin
         step(1'b0, 8'h00, 0, 1'b0);
         cmp("a5_out", seq_out, exp032[k / 3]);
         cmp("a5_fd", frame_done, k == 23);
         cmp("a5_idx", seq_idx, k / 3);
      end
      step(1'b0, 8'h00, 0, 1'b0);
      cmp("a5_wrap_out", seq_out, 1);
      cmp("a5_wrap_fd", frame_done, 0);

      for (int k = 0; k < 12; k++) step(1'b0, 8'h00, 0, 1'b0);
      cmp("slot4_idx", seq_idx, 4);
      step(1'b1, 8'hFF, 1, 1'b1);
      cmp("rst_mid_out", seq_out, 0);
      cmp("rst_mid_busy", seq_busy, 0);
      cmp("rst_mid_idx", seq_idx, 0);
      cmp("rst_mid_fd", frame_done, 0);
      step(1'b0, 8'h00, 0, 1'b0);
      cmp("rst_cfg_ignored", seq_busy, 0);

      step(1'b1, 8'h0F, 1, 1'b0);
      cmp("0f_ack", cfg_ack, 1);
      for (int k = 0; k < 16; k++) begin
         step(1'b0, 8'h00, 0, 1'b0);
         cmp("0f_out", seq_out, exp033[k % 8]);
         cmp("0f_fd", frame_done, (k % 8) == 7);
      end
      step(1'b0, 8'h00, 0, 1'b0);
      step(1'b0, 8'h00, 0, 1'b0);
      step(1'b1, 8'hFF, 2, 1'b0);
`ifdef CMD_SEQ_SHADOW_EN
      cmp("ff_deferred_ack", cfg_ack, 0);
      cmp("ff_deferred_busy", seq_busy, 1);
`else
      cmp("ff_ack", cfg_ack, 1);
      cmp("ff_load_out", seq_out, 0);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 8'h00, 0, 1'b0);
         cmp("ff_out", seq_out, 1);
         cmp("ff_idx", seq_idx, k / 2);
      end
      step(1'b1, 8'h3C, 0, 1'b0);
      cmp("stop_busy", seq_busy, 0);
      cmp("stop_out", seq_out, 0);
`endif

      for (int n = 0; n < 4000; n++) begin
         r = ($urandom_range(0, 399) == 0);
         v = ($urandom_range(0, 59) == 0);
         if (m_phase == 2 && m_pos == 8 * m_per - 1 && $urandom_range(0, 3) == 0) v = 1'b1;
         if (m_phase == 1 && $urandom_range(0, 7) == 0) v = 1'b1;
         step(v, 8'($urandom), tab[$urandom_range(0, 7)], r);
      end
      step(1'b0, 8'h00, 0, 1'b0);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
